fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the RISC-V core; owns the program counter and drives the instruction-memory request/acknowledge interface.
- Hands fetched instructions to decode with a valid/ready handshake.
- Applies redirects (branch, jump, trap) from execute and supports halt/resume.
- Keeps one fetch outstanding at a time.

---
 rtl/fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_fetch_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time, hands words to decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirects raise a sticky fault and park the fetcher in HALT.
module fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted,
  output logic            fault
);

  // Decode handshake: a word transfers on any cycle with inst_valid & inst_ready;
  // inst_valid never drops and inst_out/inst_pc never change until that transfer
  // happens, except when a redirect flushes the held word.
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_OUT, S_HALT} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pend_pc;
  logic            pend;
  logic            fault_q;
  logic [XLEN-1:0] tgt;
  logic            bad;

  assign tgt = redirect_pc & ~XLEN'(3);

`ifdef FETCH_ALIGN_CHECK_EN
  assign bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign bad = 1'b0;
`endif

  assign imem_addr = pc;
  assign fault     = fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      pend       <= 1'b0;
      pend_pc    <= '0;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      inst_pc    <= '0;
      halted     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      if (bad) fault_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (redirect_valid && !bad) pc <= tgt;
          if (halt || bad) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (!redirect_valid) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            pend     <= 1'b0;
            // A fault seen while waiting still lets the memory finish, then drops the word.
            if (fault_q || bad) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else if (redirect_valid) begin
              pc    <= tgt;
              state <= S_IDLE;
            end else if (pend) begin
              pc    <= pend_pc;
              state <= S_IDLE;
            end else begin
              inst_out   <= imem_rdata;
              inst_pc    <= pc;
              pc         <= pc + XLEN'(4);
              inst_valid <= 1'b1;
              state      <= S_OUT;
            end
          end else if (redirect_valid && !bad) begin
            pend    <= 1'b1;
            pend_pc <= tgt;
          end
        end
        S_OUT: begin
          if (redirect_valid) begin
            inst_valid <= 1'b0;
            if (bad) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              pc    <= tgt;
              state <= S_IDLE;
            end
          end else if (inst_ready) begin
            inst_valid <= 1'b0;
            if (halt) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state    <= S_FETCH;
              imem_req <= 1'b1;
            end
          end
        end
        S_HALT: begin
          if (redirect_valid && !bad) pc <= tgt;
          if (!halt && !fault_q && !bad) begin
            state  <= S_IDLE;
            halted <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed walk through the fetch/redirect/halt cases, then randomized
// traffic, every cycle compared against a flag-based reference model of the fetcher.
module tb_fetch_ctrl;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        halted;
  logic        fault;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // Reference model: which activity the fetcher is in is held as independent flags
  // (request outstanding / word held for decode / parked); none set means idle.
  logic        m_req, m_valid, m_halted, m_fault, m_pend;
  logic [31:0] m_pc, m_pend_pc, m_out, m_ipc;

  task automatic model_reset();
    m_req = 0; m_valid = 0; m_halted = 0; m_fault = 0; m_pend = 0;
    m_pc = 32'h0000_3000; m_pend_pc = '0; m_out = '0; m_ipc = '0;
  endtask

  task automatic model_step();
    logic [31:0] t;
    logic        b;
    t = {redirect_pc[31:2], 2'b00};
    b = ALIGN && redirect_valid && (redirect_pc[1:0] != 2'b00);
    if (b) m_fault = 1;
    if (m_req) begin
      if (imem_ack) begin
        m_req = 0;
        if (m_fault) m_halted = 1;
        else if (redirect_valid) m_pc = t;
        else if (m_pend) m_pc = m_pend_pc;
        else begin
          m_valid = 1; m_out = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4;
        end
        m_pend = 0;
      end else if (redirect_valid && !b) begin
        m_pend = 1; m_pend_pc = t;
      end
    end else if (m_valid) begin
      if (redirect_valid) begin
        m_valid = 0;
        if (b) m_halted = 1; else m_pc = t;
      end else if (inst_ready) begin
        m_valid = 0;
        if (halt) m_halted = 1; else m_req = 1;
      end
    end else if (m_halted) begin
      if (redirect_valid && !b) m_pc = t;
      if (!halt && !m_fault) m_halted = 0;
    end else begin
      if (redirect_valid && !b) m_pc = t;
      if (halt || b) m_halted = 1;
      else if (!redirect_valid) m_req = 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
    chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
    chk("inst_out", inst_out, m_out);
    chk("inst_pc", inst_pc, m_ipc);
    chk("halted", {31'b0, halted}, {31'b0, m_halted});
    chk("fault", {31'b0, fault}, {31'b0, m_fault});
  endtask

  task automatic cycle(input logic a, input logic [31:0] rd, input logic rdy,
                       input logic rv, input logic [31:0] rp, input logic h);
    @(negedge clk);
    imem_ack = a; imem_rdata = rd; inst_ready = rdy;
    redirect_valid = rv; redirect_pc = rp; halt = h;
    @(posedge clk);
    #1;
    if (rst) model_reset(); else model_step();
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b1, $urandom, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, $urandom, 1'b0, 1'b0, '0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic        a, rv, h_lvl;
    logic [31:0] rp;

    do_reset();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_3000);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);

    // stale ack after reset is ignored; first fetch goes to RESET_PC
    cycle(1, 32'hBAD0_BAD0, 0, 0, 0, 0);
    chk("seq_req0", {31'b0, imem_req}, 32'd1);
    chk("seq_addr0", imem_addr, 32'h0000_3000);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 32'h13, 0, 0, 0, 0);
    chk("seq_pc0", inst_pc, 32'h0000_3000);
    chk("seq_out0", inst_out, 32'h13);
    cycle(0, 0, 1, 0, 0, 0);
    chk("seq_addr1", imem_addr, 32'h0000_3004);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 32'h13, 0, 0, 0, 0);
    chk("seq_pc1", inst_pc, 32'h0000_3004);

    // decode stall: word held, no new request
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      chk("stall_valid", {31'b0, inst_valid}, 32'd1);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
      chk("stall_pc", inst_pc, 32'h0000_3004);
    end
    cycle(0, 0, 1, 0, 0, 0);
    chk("seq_addr2", imem_addr, 32'h0000_3008);

    // redirect while waiting for ack: address held, word discarded
    cycle(0, 0, 0, 1, 32'h0000_4000, 0);
    chk("pend_addr", imem_addr, 32'h0000_3008);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("pend_addr2", imem_addr, 32'h0000_3008);
    cycle(1, 32'hDEAD_BEEF, 1, 0, 0, 0);
    chk("pend_drop", {31'b0, inst_valid}, 32'd0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("pend_target", imem_addr, 32'h0000_4000);

    // redirect in the ack cycle
    cycle(1, 32'h1234, 1, 1, 32'h0000_5000, 0);
    chk("same_drop", {31'b0, inst_valid}, 32'd0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("same_target", imem_addr, 32'h0000_5000);

    // redirect in OUT drops an accepted word; then wrap at top of memory
    cycle(1, 32'h33, 0, 0, 0, 0);
    chk("out_pc", inst_pc, 32'h0000_5000);
    cycle(0, 0, 1, 1, 32'hFFFF_FFFC, 0);
    chk("out_drop", {31'b0, inst_valid}, 32'd0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cycle(1, 32'h44, 0, 0, 0, 0);
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    cycle(0, 0, 1, 0, 0, 0);
    chk("wrap_next", imem_addr, 32'h0000_0000);

    // halt during fetch: word delivered, then parked, then resume at pc+4
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 32'h55, 0, 0, 0, 1);
    chk("halt_deliver", {31'b0, inst_valid}, 32'd1);
    cycle(0, 0, 1, 0, 0, 1);
    chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_req", {31'b0, imem_req}, 32'd0);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("resume_halted", {31'b0, halted}, 32'd0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("resume_addr", imem_addr, 32'h0000_0004);

    // misaligned redirect from OUT
    cycle(1, 32'h66, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h0000_3002, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_fault", {31'b0, fault}, 32'd1);
    chk("mis_halted", {31'b0, halted}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      chk("mis_sticky", {31'b0, halted}, 32'd1);
    end
    do_reset();
    chk("mis_clear", {31'b0, fault}, 32'd0);
`else
    chk("mis_nofault", {31'b0, fault}, 32'd0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("mis_aligned", imem_addr, 32'h0000_3000);
`endif

    // randomized traffic with periodic resets
    h_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 249) begin
        do_reset();
        continue;
      end
      a  = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      rv = ($urandom_range(0, 11) == 0);
      rp = $urandom;
      if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
      if ($urandom_range(0, 19) == 0) h_lvl = ~h_lvl;
      cycle(a, $urandom, 1'($urandom_range(0, 1)), rv, rp, h_lvl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
